// File: rtl/ibex_fetch_pkg.sv
// Shared types and constants for the instruction fetch request controller.
package ibex_fetch_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_GNT = 1'b1
    } fetch_state_e;

    localparam logic [31:0] FETCH_WORD_INCR  = 32'd4;
    localparam logic [31:0] FETCH_ALIGN_MASK = 32'hFFFF_FFFC;

    // Force an address onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & FETCH_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/ibex_fetch_req_ctrl_if.sv
// Instruction bus (req/gnt/rvalid) plus FIFO push port of the fetch request controller.
// Optional macro IBEX_FETCH_PMP_EN adds the instr_pmp_err qualifier.
interface ibex_fetch_req_ctrl_if #(
    parameter int NUM_REQS = 2
) ();

    // instruction memory bus
    logic                instr_req;
    logic                instr_gnt;
    logic [31:0]         instr_addr;
    logic                instr_rvalid;
    logic [31:0]         instr_rdata;
    logic                instr_err;
`ifdef IBEX_FETCH_PMP_EN
    logic                instr_pmp_err;
`endif

    // FIFO push side
    logic                fifo_clear;
    logic [31:0]         fifo_addr;
    logic                fifo_valid;
    logic [31:0]         fifo_rdata;
    logic                fifo_err;
    logic [NUM_REQS-1:0] fifo_busy;

    // controller side
    modport master (
`ifdef IBEX_FETCH_PMP_EN
        input  instr_pmp_err,
`endif
        output instr_req, instr_addr,
        input  instr_gnt, instr_rvalid, instr_rdata, instr_err,
        output fifo_clear, fifo_addr, fifo_valid, fifo_rdata, fifo_err,
        input  fifo_busy
    );

    // memory + FIFO side
    modport slave (
`ifdef IBEX_FETCH_PMP_EN
        output instr_pmp_err,
`endif
        input  instr_req, instr_addr,
        output instr_gnt, instr_rvalid, instr_rdata, instr_err,
        input  fifo_clear, fifo_addr, fifo_valid, fifo_rdata, fifo_err,
        output fifo_busy
    );

endinterface

// File: rtl/ibex_fetch_outstanding.sv
// Slot tracker for in-flight fetch transactions. Slots fill from bit 0 upward;
// a pop shifts everything down one place, then a grant claims the lowest free slot.
// With IBEX_FETCH_PMP_EN each slot also records whether it was a PMP-faulted request.
module ibex_fetch_outstanding #(
    parameter int NUM_REQS = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                gnt,        // accepted request (bus or internal)
    input  logic                pop,        // oldest slot retired
    input  logic                branch,     // mark everything already in flight stale
`ifdef IBEX_FETCH_PMP_EN
    input  logic                pmp_err,    // accepted request is PMP-faulted
    output logic [NUM_REQS-1:0] pmp_q,
`endif
    output logic [NUM_REQS-1:0] outstanding_q,
    output logic [NUM_REQS-1:0] discard_q
);

    logic [NUM_REQS-1:0] out_s, disc_s, ins;
    logic [NUM_REQS-1:0] outstanding_d, discard_d;
`ifdef IBEX_FETCH_PMP_EN
    logic [NUM_REQS-1:0] pmp_s, pmp_d;
`endif

    // Shift on pop, mark stale on branch, then insert the newly accepted request.
    always_comb begin
        out_s  = outstanding_q;
        disc_s = discard_q;
`ifdef IBEX_FETCH_PMP_EN
        pmp_s  = pmp_q;
`endif
        if (pop) begin
            out_s  = outstanding_q >> 1;
            disc_s = discard_q >> 1;
`ifdef IBEX_FETCH_PMP_EN
            pmp_s  = pmp_q >> 1;
`endif
        end
        // The request granted alongside a branch carries the new target, so only
        // slots that already existed are made stale.
        if (branch) begin
            disc_s = disc_s | out_s;
        end
        // lowest free slot: free here, occupied (or floor) below
        ins = ~out_s & {out_s[NUM_REQS-2:0], 1'b1};
        if (!gnt) begin
            ins = '0;
        end
        outstanding_d = out_s | ins;
        discard_d     = disc_s & ~ins;
`ifdef IBEX_FETCH_PMP_EN
        pmp_d         = (pmp_s & ~ins) | (pmp_err ? ins : '0);
`endif
    end

    // Tracker state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
            discard_q     <= '0;
`ifdef IBEX_FETCH_PMP_EN
            pmp_q         <= '0;
`endif
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
`ifdef IBEX_FETCH_PMP_EN
            pmp_q         <= pmp_d;
`endif
        end
    end

endmodule

// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction fetch request controller: issues word-aligned requests, tracks up to
// NUM_REQS in-flight transactions, drops responses made stale by a branch and pushes
// the survivors into the fetch FIFO.
// Optional macro IBEX_FETCH_PMP_EN: PMP-faulted requests are retired internally and
// pushed as error entries in order.
module ibex_fetch_req_ctrl
    import ibex_fetch_pkg::*;
#(
    parameter int NUM_REQS = 2,
    parameter bit ResetAll = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  branch_i,
    input  logic [31:0]           addr_i,
    output logic                  busy_o,
    ibex_fetch_req_ctrl_if.master bus
);

    fetch_state_e        state_q, state_d;
    logic [31:0]         fetch_addr_q, fetch_addr_d;
    logic [31:0]         stored_addr_q, stored_addr_d;
    logic [31:0]         req_addr;
    logic [NUM_REQS-1:0] outstanding_q, discard_q, outstanding_rev;
    logic                fifo_ready, valid_new_req, req_int, gnt_eff, accept, pop, pmp_err;
    logic                rsp_pop, rsp_keep, pmp_pop;

`ifdef IBEX_FETCH_PMP_EN
    logic [NUM_REQS-1:0] pmp_q;
    assign pmp_err = bus.instr_pmp_err;
    assign pmp_pop = outstanding_q[0] & pmp_q[0];
`else
    assign pmp_err = 1'b0;
    assign pmp_pop = 1'b0;
`endif

    // Reverse the slot vector so the oldest slots line up against the FIFO's busy flags.
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            outstanding_rev[i] = outstanding_q[NUM_REQS-1-i];
        end
    end

    assign fifo_ready    = ~&(bus.fifo_busy | outstanding_rev);
    assign valid_new_req = req_i & (fifo_ready | branch_i) & ~outstanding_q[NUM_REQS-1];
    // WAIT_GNT keeps the request up even after req_i drops.
    assign req_int       = valid_new_req | (state_q == WAIT_GNT);
    // A faulted request never reaches the bus and counts as granted on the spot.
    assign bus.instr_req = req_int & ~pmp_err;
    assign gnt_eff       = bus.instr_gnt | pmp_err;
    assign accept        = req_int & gnt_eff;
    assign busy_o        = |outstanding_q | req_int;

    // Request FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (req_int && !gnt_eff) state_d = WAIT_GNT;
            WAIT_GNT: if (gnt_eff)             state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Request FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address mux and next values of the address registers.
    always_comb begin
        if (branch_i) begin
            req_addr = align_word(addr_i);
        end else if (state_q == WAIT_GNT) begin
            req_addr = stored_addr_q;
        end else begin
            req_addr = fetch_addr_q;
        end

        stored_addr_d = stored_addr_q;
        if (req_int && !gnt_eff) begin
            stored_addr_d = req_addr;
        end

        // A grant in the branch cycle is for the target itself, so grant wins.
        fetch_addr_d = fetch_addr_q;
        if (accept) begin
            fetch_addr_d = req_addr + FETCH_WORD_INCR;
        end else if (branch_i) begin
            fetch_addr_d = align_word(addr_i);
        end
    end

    assign bus.instr_addr = req_addr;

    if (ResetAll) begin : g_addr_rst
        // Address registers with asynchronous reset.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                fetch_addr_q  <= '0;
                stored_addr_q <= '0;
            end else begin
                fetch_addr_q  <= fetch_addr_d;
                stored_addr_q <= stored_addr_d;
            end
        end
    end else begin : g_addr_nrst
        // Address registers without reset; meaningful only after the first branch.
        always_ff @(posedge clk_i) begin
            fetch_addr_q  <= fetch_addr_d;
            stored_addr_q <= stored_addr_d;
        end
    end

    assign pop = bus.instr_rvalid | pmp_pop;

    ibex_fetch_outstanding #(
        .NUM_REQS (NUM_REQS)
    ) u_outstanding (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .gnt           (accept),
        .pop           (pop),
        .branch        (branch_i),
`ifdef IBEX_FETCH_PMP_EN
        .pmp_err       (pmp_err),
        .pmp_q         (pmp_q),
`endif
        .outstanding_q (outstanding_q),
        .discard_q     (discard_q)
    );

    // An injected PMP error entry takes the place of a bus response.
    assign rsp_pop        = bus.instr_rvalid | pmp_pop;
    assign rsp_keep       = ~discard_q[0] & ~branch_i;
    assign bus.fifo_valid = rsp_pop & rsp_keep;
    assign bus.fifo_rdata = pmp_pop ? 32'h0 : bus.instr_rdata;
    assign bus.fifo_err   = pmp_pop | bus.instr_err;
    assign bus.fifo_clear = branch_i;
    assign bus.fifo_addr  = addr_i;

    // A response with nothing in flight means the bus broke protocol.
    a_rvalid_tracked: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.instr_rvalid |-> |outstanding_q)
        else $error("rvalid with no outstanding request");

`ifdef IBEX_FETCH_PMP_EN
    // The slot at position 0 is either a real bus response or a PMP entry, never both.
    a_pmp_no_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pmp_pop |-> !bus.instr_rvalid)
        else $error("rvalid while a PMP entry is at the head");
`endif

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Directed bench for ibex_fetch_req_ctrl; expected values are hand-derived per cycle.
module tb_ibex_fetch_req_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i, branch_i;
    logic [31:0] addr_i;
    logic        busy_o;
    int          checks = 0;
    int          failures = 0;

    ibex_fetch_req_ctrl_if #(.NUM_REQS(2)) bus ();

    ibex_fetch_req_ctrl #(.NUM_REQS(2), .ResetAll(1'b0)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .branch_i (branch_i),
        .addr_i   (addr_i),
        .busy_o   (busy_o),
        .bus      (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle's inputs; checks follow #1 later, before the next rising edge.
    task automatic drive(input logic req, input logic br, input logic [31:0] addr,
                         input logic gnt, input logic rv, input logic [31:0] rdata,
                         input logic err, input logic [1:0] fbusy);
        req_i            = req;
        branch_i         = br;
        addr_i           = addr;
        bus.instr_gnt    = gnt;
        bus.instr_rvalid = rv;
        bus.instr_rdata  = rdata;
        bus.instr_err    = err;
        bus.fifo_busy    = fbusy;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk_i);
    endtask

    initial begin
        rst_ni = 1'b0;
`ifdef IBEX_FETCH_PMP_EN
        bus.instr_pmp_err = 1'b0;
`endif
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 2'b00);
        next_cycle();
        next_cycle();
        chk("rst_req",   32'(bus.instr_req),  0);
        chk("rst_valid", 32'(bus.fifo_valid), 0);
        chk("rst_clear", 32'(bus.fifo_clear), 0);
        chk("rst_busy",  32'(busy_o),         0);
        rst_ni = 1'b1;
        next_cycle();

        // branch to 0x80 with immediate grant
        drive(1, 1, 32'h80, 1, 0, 32'h0, 0, 2'b00);
        chk("br_req",   32'(bus.instr_req), 1);
        chk("br_addr",  bus.instr_addr,     32'h80);
        chk("br_clear", 32'(bus.fifo_clear), 1);
        chk("br_faddr", bus.fifo_addr,      32'h80);
        chk("br_noval", 32'(bus.fifo_valid), 0);
        next_cycle();
        // 0x84 requested, grant withheld, first response arrives
        drive(1, 0, 32'h0, 0, 1, 32'hA1A1_0001, 0, 2'b00);
        chk("s1_addr",  bus.instr_addr,      32'h84);
        chk("s1_req",   32'(bus.instr_req),  1);
        chk("s1_valid", 32'(bus.fifo_valid), 1);
        chk("s1_rdata", bus.fifo_rdata,      32'hA1A1_0001);
        chk("s1_clear", 32'(bus.fifo_clear), 0);
        next_cycle();
        // WAIT_GNT holds request and address although req_i is low
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 2'b00);
            chk("wg_req",  32'(bus.instr_req), 1);
            chk("wg_addr", bus.instr_addr,     32'h84);
            chk("wg_busy", 32'(busy_o),        1);
            next_cycle();
        end
        drive(0, 0, 32'h0, 1, 0, 32'h0, 0, 2'b00);
        chk("wg_gnt_req",  32'(bus.instr_req), 1);
        chk("wg_gnt_addr", bus.instr_addr,     32'h84);
        next_cycle();
        drive(0, 0, 32'h0, 0, 1, 32'hA1A1_0002, 1, 2'b00);
        chk("s2_addr",  bus.instr_addr,      32'h88);
        chk("s2_req",   32'(bus.instr_req),  0);
        chk("s2_valid", 32'(bus.fifo_valid), 1);
        chk("s2_rdata", bus.fifo_rdata,      32'hA1A1_0002);
        chk("s2_err",   32'(bus.fifo_err),   1);
        next_cycle();
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 2'b00);
        chk("s2_idle_busy", 32'(busy_o), 0);

        // two in flight (0x100, 0x104), then branch to 0x202
        drive(1, 1, 32'h100, 1, 0, 32'h0, 0, 2'b00);
        chk("t3_a0", bus.instr_addr, 32'h100);
        next_cycle();
        drive(1, 0, 32'h0, 1, 0, 32'h0, 0, 2'b00);
        chk("t3_a1",   bus.instr_addr,     32'h104);
        chk("t3_req1", 32'(bus.instr_req), 1);
        next_cycle();
        drive(1, 1, 32'h202, 0, 0, 32'h0, 0, 2'b00);
        chk("t3_full_req", 32'(bus.instr_req),  0);
        chk("t3_br_addr",  bus.instr_addr,      32'h200);
        chk("t3_br_faddr", bus.fifo_addr,       32'h202);
        next_cycle();
        drive(1, 0, 32'h0, 0, 1, 32'hB0B0_0001, 0, 2'b00);
        chk("t3_stale1", 32'(bus.fifo_valid), 0);
        chk("t3_full2",  32'(bus.instr_req),  0);
        next_cycle();
        drive(1, 0, 32'h0, 1, 1, 32'hB0B0_0002, 0, 2'b00);
        chk("t3_stale2", 32'(bus.fifo_valid), 0);
        chk("t3_req200", 32'(bus.instr_req),  1);
        chk("t3_a200",   bus.instr_addr,      32'h200);
        next_cycle();
        drive(0, 0, 32'h0, 0, 1, 32'hB0B0_0003, 0, 2'b00);
        chk("t3_keep",  32'(bus.fifo_valid), 1);
        chk("t3_rdata", bus.fifo_rdata,      32'hB0B0_0003);
        next_cycle();

        // FIFO throttle, then branch override
        drive(1, 0, 32'h0, 1, 0, 32'h0, 0, 2'b00);
        chk("t4_a204", bus.instr_addr, 32'h204);
        next_cycle();
        drive(1, 0, 32'h0, 0, 0, 32'h0, 0, 2'b11);
        chk("t4_thr_req",  32'(bus.instr_req), 0);
        chk("t4_thr_busy", 32'(busy_o),        1);
        next_cycle();
        drive(1, 0, 32'h0, 0, 0, 32'h0, 0, 2'b01);
        chk("t4_thr01_req", 32'(bus.instr_req), 0);
        drive(1, 0, 32'h0, 0, 0, 32'h0, 0, 2'b00);
        chk("t4_drain_req", 32'(bus.instr_req), 1);
        chk("t4_drain_addr", bus.instr_addr,    32'h208);
        drive(1, 1, 32'h300, 1, 0, 32'h0, 0, 2'b11);
        chk("t4_ovr_req",  32'(bus.instr_req), 1);
        chk("t4_ovr_addr", bus.instr_addr,     32'h300);
        next_cycle();
        drive(1, 0, 32'h0, 0, 1, 32'hC0C0_0001, 0, 2'b11);
        chk("t4_stale", 32'(bus.fifo_valid), 0);
        chk("t4_full",  32'(bus.instr_req),  0);
        next_cycle();
        drive(0, 0, 32'h0, 0, 1, 32'hC0C0_0002, 0, 2'b00);
        chk("t4_keep",  32'(bus.fifo_valid), 1);
        chk("t4_rdata", bus.fifo_rdata,      32'hC0C0_0002);
        next_cycle();

        // address wrap
        drive(1, 1, 32'hFFFF_FFFE, 1, 0, 32'h0, 0, 2'b00);
        chk("t5_addr",  bus.instr_addr, 32'hFFFF_FFFC);
        chk("t5_faddr", bus.fifo_addr,  32'hFFFF_FFFE);
        next_cycle();
        drive(1, 0, 32'h0, 0, 0, 32'h0, 0, 2'b00);
        chk("t5_wrap", bus.instr_addr, 32'h0000_0000);
        next_cycle();
        drive(0, 0, 32'h0, 1, 1, 32'hD0D0_0001, 0, 2'b00);
        chk("t5_wg_addr", bus.instr_addr,      32'h0000_0000);
        chk("t5_push",    32'(bus.fifo_valid), 1);
        next_cycle();
        drive(0, 0, 32'h0, 0, 1, 32'hD0D0_0002, 0, 2'b00);
        chk("t5_push2", bus.fifo_rdata, 32'hD0D0_0002);
        next_cycle();
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 2'b00);
        chk("t5_idle", 32'(busy_o), 0);

`ifdef IBEX_FETCH_PMP_EN
        // PMP fault on the second request
        drive(1, 1, 32'h400, 1, 0, 32'h0, 0, 2'b00);
        chk("p_a400", bus.instr_addr, 32'h400);
        next_cycle();
        bus.instr_pmp_err = 1'b1;
        drive(1, 0, 32'h0, 0, 0, 32'h0, 0, 2'b00);
        chk("p_noreq", 32'(bus.instr_req), 0);
        next_cycle();
        bus.instr_pmp_err = 1'b0;
        drive(0, 0, 32'h0, 0, 1, 32'hE0E0_0001, 0, 2'b00);
        chk("p_first_v", 32'(bus.fifo_valid), 1);
        chk("p_first_e", 32'(bus.fifo_err),   0);
        next_cycle();
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 2'b00);
        chk("p_inj_v", 32'(bus.fifo_valid), 1);
        chk("p_inj_e", 32'(bus.fifo_err),   1);
        chk("p_inj_d", bus.fifo_rdata,      32'h0);
        next_cycle();
        chk("p_idle", 32'(busy_o), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
